// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared widths, opcodes, bubble encoding, IF FSM state encoding and the
// IF/ID payload record used by the fetch unit and its predictor.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam int unsigned WIDTH_PC   = 32;
  localparam int unsigned WIDTH_INST = 32;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [WIDTH_INST-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_KILL = 2'd3
  } if_state_e;

  // One IF/ID payload: also the format of the single-entry hold buffer.
  typedef struct packed {
    logic [WIDTH_PC-1:0]   pc;
    logic [WIDTH_INST-1:0] inst;
    logic                  valid;
    logic                  pred;
  } if_slot_t;

  function automatic logic [WIDTH_PC-1:0] align_pc(input logic [WIDTH_PC-1:0] pc);
    return {pc[WIDTH_PC-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_btfn_predictor.sv
// ---------------------------------------------------------------------------
// if_btfn_predictor
// Static backward-taken / forward-not-taken predictor, purely combinational.
// JAL is always taken; a conditional branch is taken when its offset is
// negative (imm[12] = inst[31]).
// Ports:
//   i_inst    fetched instruction
//   i_pc      address of i_inst
//   o_taken   predicted taken
//   o_target  i_pc + sign-extended J/B immediate
// Only instantiated when IF_BTFN_PREDICT_EN is defined.
// ---------------------------------------------------------------------------
module if_btfn_predictor
  import if_fetch_unit_pkg::*;
(
  input  logic [WIDTH_INST-1:0] i_inst,
  input  logic [WIDTH_PC-1:0]   i_pc,
  output logic                  o_taken,
  output logic [WIDTH_PC-1:0]   o_target
);

  logic [6:0]          w_opcode;
  logic                w_is_jal;
  logic                w_is_branch;
  logic [WIDTH_PC-1:0] w_imm_j;
  logic [WIDTH_PC-1:0] w_imm_b;

  always_comb begin
    w_opcode    = i_inst[6:0];
    w_is_jal    = (w_opcode == OPCODE_JAL);
    w_is_branch = (w_opcode == OPCODE_BRANCH);
    w_imm_j     = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
    w_imm_b     = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
    o_taken     = w_is_jal | (w_is_branch & i_inst[31]);
    o_target    = i_pc + (w_is_jal ? w_imm_j : w_imm_b);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// imem request/response handshake and drives {pc, inst} into IF/ID. A NOP
// bubble is emitted whenever no fetched instruction is ready. stop_IF holds
// the outputs (a response arriving meanwhile lands in a 1-entry hold
// buffer); redirect_i flushes and retargets with top priority.
// Parameters:
//   RESET_PC  fetch address after reset
//   NOP_INST  bubble encoding
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   stop_IF                             hazard hold
//   redirect_i, redirect_pc_i           EX flush + target
//   imem_req_o, imem_addr_o             request valid / word address
//   imem_gnt_i                          request accepted
//   imem_rvalid_i, imem_rdata_i         response
//   pc_o, inst_o, inst_valid_o          IF/ID payload
//   pred_taken_o                        static prediction for inst_o
// Configuration:
//   IF_BTFN_PREDICT_EN  enables the BTFN predictor (pred_taken_o tied 0 otherwise)
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [WIDTH_PC-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH_INST-1:0] NOP_INST = INST_NOP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stop_IF,
  input  logic                  redirect_i,
  input  logic [WIDTH_PC-1:0]   redirect_pc_i,
  output logic                  imem_req_o,
  output logic [WIDTH_PC-1:0]   imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [WIDTH_INST-1:0] imem_rdata_i,
  output logic [WIDTH_PC-1:0]   pc_o,
  output logic [WIDTH_INST-1:0] inst_o,
  output logic                  inst_valid_o,
  output logic                  pred_taken_o
);

  if_state_e           r_state,    w_state_d;
  logic [WIDTH_PC-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [WIDTH_PC-1:0] r_req_pc,   w_req_pc_d;
  if_slot_t            r_out,      w_out_d;
  if_slot_t            r_buf,      w_buf_d;

  logic                w_gnt;
  logic                w_rsp;
  logic [WIDTH_PC-1:0] w_redir_pc;
  if_slot_t            w_rsp_slot;
  logic                w_pred_taken;

`ifdef IF_BTFN_PREDICT_EN
  logic [WIDTH_PC-1:0] w_pred_target;

  if_btfn_predictor u_predictor (
    .i_inst   (imem_rdata_i),
    .i_pc     (r_req_pc),
    .o_taken  (w_pred_taken),
    .o_target (w_pred_target)
  );
`else
  assign w_pred_taken = 1'b0;
`endif

  // A full hold buffer blocks new requests so at most one instruction is
  // ever waiting behind a stall.
  assign imem_req_o  = (r_state == S_REQ) && !r_buf.valid;
  assign imem_addr_o = r_fetch_pc;

  assign pc_o         = r_out.pc;
  assign inst_o       = r_out.inst;
  assign inst_valid_o = r_out.valid;
  assign pred_taken_o = r_out.pred;

  always_comb begin
    w_gnt      = imem_req_o & imem_gnt_i;
    // Only an S_WAIT response without a same-cycle redirect is kept.
    w_rsp      = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
    w_redir_pc = align_pc(redirect_pc_i);
    w_rsp_slot = '{pc: r_req_pc, inst: imem_rdata_i, valid: 1'b1, pred: w_pred_taken};
  end

  // Next-state and fetch PC.
  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_req_pc_d   = r_req_pc;

    unique case (r_state)
      S_IDLE: w_state_d = S_REQ;
      S_REQ: begin
        if (w_gnt) begin
          if (redirect_i) begin
            w_state_d = S_KILL;
          end else begin
            w_state_d    = S_WAIT;
            w_req_pc_d   = r_fetch_pc;
            w_fetch_pc_d = r_fetch_pc + 32'd4;
          end
        end
      end
      S_WAIT: begin
        // A response arriving with the redirect still retires the
        // outstanding request, so there is nothing left to kill.
        if (imem_rvalid_i) begin
          w_state_d = S_REQ;
        end else if (redirect_i) begin
          w_state_d = S_KILL;
        end
`ifdef IF_BTFN_PREDICT_EN
        if (w_rsp && w_pred_taken) begin
          w_fetch_pc_d = w_pred_target;
        end
`endif
      end
      S_KILL: begin
        if (imem_rvalid_i) begin
          w_state_d = S_REQ;
        end
      end
      default: w_state_d = S_IDLE;
    endcase

    if (redirect_i) begin
      w_fetch_pc_d = w_redir_pc;
    end
  end

  // IF/ID outputs and hold buffer.
  always_comb begin
    w_out_d = r_out;
    w_buf_d = r_buf;

    if (redirect_i) begin
      w_out_d       = '{pc: w_redir_pc, inst: NOP_INST, valid: 1'b0, pred: 1'b0};
      w_buf_d.valid = 1'b0;
    end else if (!stop_IF) begin
      if (r_buf.valid) begin
        w_out_d       = r_buf;
        w_buf_d.valid = 1'b0;
      end else if (w_rsp) begin
        w_out_d = w_rsp_slot;
      end else begin
        w_out_d = '{pc: r_out.pc, inst: NOP_INST, valid: 1'b0, pred: 1'b0};
      end
    end else if (w_rsp) begin
      w_buf_d = w_rsp_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= align_pc(RESET_PC);
      r_req_pc   <= align_pc(RESET_PC);
      r_out      <= '{pc: RESET_PC, inst: NOP_INST, valid: 1'b0, pred: 1'b0};
      r_buf      <= '{pc: RESET_PC, inst: NOP_INST, valid: 1'b0, pred: 1'b0};
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_req_pc   <= w_req_pc_d;
      r_out      <= w_out_d;
      r_buf      <= w_buf_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed per-cycle vectors for if_fetch_unit. Each row gives the inputs
// driven for one cycle and the outputs expected during that cycle (request
// signals reflect the current state, IF/ID outputs the previous edge).
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stop_IF;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        pred_taken_o;

  if_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stop_IF       (stop_IF),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .pred_taken_o  (pred_taken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic        redir;
    logic [31:0] redir_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_pred;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic stop, input logic redir, input logic [31:0] redir_pc,
                              input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic e_valid, input logic e_pred);
    vec_t v;
    v.stop = stop;     v.redir = redir;   v.redir_pc = redir_pc;
    v.gnt = gnt;       v.rvalid = rvalid; v.rdata = rdata;
    v.e_req = e_req;   v.e_addr = e_addr; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_valid = e_valid; v.e_pred = e_pred;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic e_req, input logic [31:0] e_pc,
                             input logic [31:0] e_inst, input logic e_valid,
                             input logic e_pred);
    chk({tag, ".req"},   {31'd0, imem_req_o},   {31'd0, e_req});
    chk({tag, ".pc"},    pc_o,                  e_pc);
    chk({tag, ".inst"},  inst_o,                e_inst);
    chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, e_valid});
    chk({tag, ".pred"},  {31'd0, pred_taken_o}, {31'd0, e_pred});
  endtask

  task automatic drive_idle();
    stop_IF = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
  endtask

  initial begin
    // Reset release and back-to-back fetches of 0x0, 0x4, 0x8.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 32'h0,  32'h0, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h0,  32'h0, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00100093, 0, 32'h4,  32'h0, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h4,  32'h0, 32'h00100093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00200093, 0, 32'h8,  32'h0, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h8,  32'h4, 32'h00200093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00300093, 0, 32'hC,  32'h4, NOP, 0, 0));
    // stop_IF for 3 cycles; response parks in the hold buffer.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,            1, 32'hC,  32'h8, 32'h00300093, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h00500093, 0, 32'h10, 32'h8, 32'h00300093, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            0, 32'h10, 32'h8, 32'h00300093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 32'h10, 32'h8, 32'h00300093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h10, 32'hC, 32'h00500093, 1, 0));
    // Redirect to 0x100 in S_WAIT; late response discarded.
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h10, 32'hC, NOP, 0, 0));
    vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0,      0, 32'h14, 32'hC, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00700093, 0, 32'h100, 32'h100, NOP, 0, 0));
    // Grant delayed 4 cycles: address stable, bubbles only.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h100, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h100, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h100, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h100, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h100, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00800093, 0, 32'h104, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h104, 32'h100, 32'h00800093, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h104, 32'h100, NOP, 0, 0));
    // Unaligned redirect 0x203 while ungranted -> 0x200.
    vecs.push_back(mk(0, 1, 32'h203, 0, 0, 0,      1, 32'h104, 32'h100, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h200, 32'h200, NOP, 0, 0));
    // Redirect coincident with gnt -> kill; then wrap 0xFFFFFFFC -> 0x0.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 1, 0, 0, 1, 32'h200, 32'h200, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00110093, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00900093, 0, 32'h0, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h0, 32'hFFFF_FFFC, 32'h00900093, 1, 0));
    // Redirect during stop_IF with a full hold buffer: buffer is flushed.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,            1, 32'h0, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'h00A00093, 0, 32'h4, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(1, 1, 32'h80, 0, 0, 0,       0, 32'h4, 32'hFFFF_FFFC, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h80, 32'h80, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h80, 32'h80, NOP, 0, 0));
`ifdef IF_BTFN_PREDICT_EN
    // beq -8 at 0x40 -> predicted taken to 0x38; forward beq -> 0x44.
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0,       1, 32'h80, 32'h80, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h40, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hFE000CE3, 0, 32'h44, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h38, 32'h40, 32'hFE000CE3, 1, 1));
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0,       1, 32'h38, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            1, 32'h40, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00000463, 0, 32'h44, 32'h40, NOP, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h44, 32'h40, 32'h00000463, 1, 0));
`endif

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs("reset", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stop_IF       = vecs[i].stop;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].redir_pc;
      imem_gnt_i    = vecs[i].gnt;
      imem_rvalid_i = vecs[i].rvalid;
      imem_rdata_i  = vecs[i].rdata;
      #1;
      chk_outputs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_inst,
                  vecs[i].e_valid, vecs[i].e_pred);
      if (vecs[i].e_req) begin
        chk($sformatf("row%0d.addr", i), imem_addr_o, vecs[i].e_addr);
      end
      @(negedge clk);
    end

    // Reset with a request outstanding: everything drops immediately, and
    // the first request reappears one cycle after release at RESET_PC.
    drive_idle();
    imem_gnt_i = 1'b1;
    #1;
    chk("midrst.pre_req", {31'd0, imem_req_o}, 32'd1);
    @(negedge clk);
    imem_gnt_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs("midrst.in", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    chk("midrst.addr", imem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00C00093;
    #1;
    chk_outputs("midrst.idle", 1'b0, 32'h0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    #1;
    chk_outputs("midrst.req", 1'b1, 32'h0, NOP, 1'b0, 1'b0);
    chk("midrst.req_addr", imem_addr_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
